// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter that shares a byte-wide boot flash between two 32-bit word readers.
// Each word is fetched as four timed byte reads, assembled big-endian (byte 0 -> bits 31:24).
module flash_read_arbiter #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        req0_valid,
    input  logic [19:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [19:0] req1_addr,
    output logic        req1_ready,
    output logic [31:0] resp_data,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic        busy,
    output logic [21:0] FL_ADDR,
    input  logic [7:0]  FL_DQ,
    output logic        FL_CE_N,
    output logic        FL_OE_N,
    output logic        FL_WE_N,
    output logic        FL_RST_N
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      asm_q, asm_d;
    logic [31:0]      resp_data_q, resp_data_d;
    // fl_addr_q doubles as the latched word address (21:2) and the byte index (1:0)
    logic [21:0]      fl_addr_q, fl_addr_d;
    logic             fl_rst_q;
    logic             idle;

    assign idle       = (state_q == S_IDLE);
    assign req0_ready = Reset_n & idle & req0_valid & (~req1_valid | last_grant_q);
    assign req1_ready = Reset_n & idle & req1_valid & (~req0_valid | ~last_grant_q);

    assign resp_data   = resp_data_q;
    assign resp0_valid = (state_q == S_DONE) & ~owner_q;
    assign resp1_valid = (state_q == S_DONE) & owner_q;
    assign busy        = ~idle;
    assign FL_ADDR     = fl_addr_q;
    assign FL_CE_N     = (state_q != S_READ);
    assign FL_OE_N     = (state_q != S_READ);
    assign FL_WE_N     = 1'b1;
    assign FL_RST_N    = fl_rst_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        resp_data_d  = resp_data_q;
        fl_addr_d    = fl_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    state_d      = S_READ;
                    owner_d      = req1_ready;
                    last_grant_d = req1_ready;
                    fl_addr_d    = {(req1_ready ? req1_addr : req0_addr), 2'b00};
                    cnt_d        = '0;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // FL_DQ has been stable for WAIT_CYCLES cycles at this address
                    case (fl_addr_q[1:0])
                        2'd0: asm_d[23:16] = FL_DQ;
                        2'd1: asm_d[15:8]  = FL_DQ;
                        2'd2: asm_d[7:0]   = FL_DQ;
                        default: begin
                            resp_data_d = {asm_q, FL_DQ};
                            state_d     = S_DONE;
                        end
                    endcase
                    if (fl_addr_q[1:0] != 2'd3) begin
                        fl_addr_d = fl_addr_q + 22'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            asm_q        <= '0;
            resp_data_q  <= '0;
            fl_addr_q    <= '0;
            fl_rst_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            resp_data_q  <= resp_data_d;
            fl_addr_q    <= fl_addr_d;
            fl_rst_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: instance 0 uses WAIT_CYCLES=4, instance 1 uses WAIT_CYCLES=1.
// Drivers push expectations at each accepted transfer; per-instance monitors pop and compare responses.
module tb_flash_read_arbiter;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic [31:0] cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          pend[2];
    int          gseq[$];

    logic        r0v[2], r1v[2], r0r[2], r1r[2];
    logic [19:0] r0a[2], r1a[2];
    logic [31:0] rdata[2];
    logic        rv0[2], rv1[2], busy_o[2];
    logic [21:0] fl_addr[2];
    logic        fl_ce_n[2], fl_oe_n[2], fl_we_n[2], fl_rst_n[2];

    logic [7:0]  fmem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [19:0] a);
        case (a)
            20'h00000: return 32'h3C1D0040;
            20'h00001: return 32'h11223344;
            20'h00002: return 32'hAABBCCDD;
            20'h00005: return 32'h5AC30FF0;
            20'h00007: return 32'h01020304;
            20'hFFFFF: return 32'hDEADBEEF;
            default:   return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic load_word(input logic [19:0] a, input logic [31:0] w);
        int base;
        base = int'({a, 2'b00});
        fmem[base]     = w[31:24];
        fmem[base + 1] = w[23:16];
        fmem[base + 2] = w[15:8];
        fmem[base + 3] = w[7:0];
    endtask

    function automatic logic [7:0] flash_rd(input logic [21:0] a);
        if (fmem.exists(int'(a))) return fmem[int'(a)];
        return 8'hFF;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int W = (d == 0) ? 4 : 1;
        logic [7:0]  dq = 8'hFF;
        sb_t         sbq[$];
        sb_t         e;
        logic [19:0] acc_addr = '0;
        int          acc_cyc = 0;
        int          k;

        flash_read_arbiter #(.WAIT_CYCLES(W)) u_dut (
            .clk(clk), .Reset_n(rst_n),
            .req0_valid(r0v[d]), .req0_addr(r0a[d]), .req0_ready(r0r[d]),
            .req1_valid(r1v[d]), .req1_addr(r1a[d]), .req1_ready(r1r[d]),
            .resp_data(rdata[d]), .resp0_valid(rv0[d]), .resp1_valid(rv1[d]), .busy(busy_o[d]),
            .FL_ADDR(fl_addr[d]), .FL_DQ(dq), .FL_CE_N(fl_ce_n[d]), .FL_OE_N(fl_oe_n[d]),
            .FL_WE_N(fl_we_n[d]), .FL_RST_N(fl_rst_n[d])
        );

        // flash data settles half a cycle after the address changes
        always @(negedge clk) dq = flash_rd(fl_addr[d]);

        always @(negedge clk) begin
            if (!rst_n) begin
                sbq.delete();
                pend[d] = 0;
            end else begin
                check("we_n_high", fl_we_n[d], 1);
                check("one_ready", r0r[d] & r1r[d], 0);
                if (busy_o[d]) check("ready_in_busy", r0r[d] | r1r[d], 0);
                if (!fl_ce_n[d]) begin
                    k = (cyc - acc_cyc - 1) / W;
                    check("fl_addr", fl_addr[d], {acc_addr, k[1:0]});
                    check("oe_n_low", fl_oe_n[d], 0);
                end
                if (rv0[d] || rv1[d]) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_resp", {rv1[d], rv0[d]}, 0);
                    end else begin
                        e = sbq.pop_front();
                        pend[d]--;
                        check("resp_excl", rv0[d] & rv1[d], 0);
                        check("resp_owner", rv1[d], e.owner);
                        check("resp_data", rdata[d], e.data);
                        check("resp_cycle", cyc, e.cyc);
                    end
                end
                if ((r0v[d] && r0r[d]) || (r1v[d] && r1r[d])) begin
                    e.owner  = r1v[d] && r1r[d];
                    acc_addr = e.owner ? r1a[d] : r0a[d];
                    e.data   = exp_word(acc_addr);
                    e.cyc    = cyc + 4 * W + 1;
                    acc_cyc  = cyc;
                    sbq.push_back(e);
                    pend[d]++;
                end
            end
        end
    end

    task automatic do_reset();
        #2 rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r0v[d] = 1'b1;
            r1v[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ce_n", fl_ce_n[d], 1);
            check("rst_oe_n", fl_oe_n[d], 1);
            check("rst_we_n", fl_we_n[d], 1);
            check("rst_fl_rst_n", fl_rst_n[d], 0);
            check("rst_fl_addr", fl_addr[d], 0);
            check("rst_resp_data", rdata[d], 0);
            check("rst_resp_valid", {rv1[d], rv0[d]}, 0);
            check("rst_busy", busy_o[d], 0);
            check("rst_ready", {r1r[d], r0r[d]}, 0);
        end
        for (int d = 0; d < 2; d++) begin
            r0v[d] = 1'b0;
            r1v[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check("fl_rst_n_hold", fl_rst_n[d], 0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check("fl_rst_n_rise", fl_rst_n[d], 1);
    endtask

    // hold each valid until it has been granted n0/n1 times, recording grant order
    task automatic drive_pair(input int d, input logic [19:0] a0, input logic [19:0] a1,
                              input int n0, input int n1);
        logic g0, g1;
        @(posedge clk);
        #1;
        r0a[d] = a0;
        r1a[d] = a1;
        r0v[d] = (n0 > 0);
        r1v[d] = (n1 > 0);
        for (int t = 0; t < 400 && (n0 > 0 || n1 > 0); t++) begin
            @(negedge clk);
            g0 = r0v[d] & r0r[d];
            g1 = r1v[d] & r1r[d];
            if (g0) begin gseq.push_back(0); n0--; end
            if (g1) begin gseq.push_back(1); n1--; end
            @(posedge clk);
            #1;
            if (g0 && n0 == 0) r0v[d] = 1'b0;
            if (g1 && n1 == 0) r1v[d] = 1'b0;
        end
        check("grant_timeout", n0 + n1, 0);
        r0v[d] = 1'b0;
        r1v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (pend[d] == 0 && !busy_o[d]) break;
        end
        check("drain", pend[d], 0);
    endtask

    int exp_g[4] = '{0, 1, 0, 1};

    initial begin
        for (int d = 0; d < 2; d++) begin
            r0v[d] = 1'b0; r1v[d] = 1'b0;
            r0a[d] = '0;   r1a[d] = '0;
            pend[d] = 0;
        end
        load_word(20'h00000, 32'h3C1D0040);
        load_word(20'h00001, 32'h11223344);
        load_word(20'h00002, 32'hAABBCCDD);
        load_word(20'h00005, 32'h5AC30FF0);
        load_word(20'h00007, 32'h01020304);
        load_word(20'hFFFFF, 32'hDEADBEEF);

        do_reset();

        // single req0 read of word 0
        drive_pair(0, 20'h00000, 20'h00000, 1, 0);
        wait_idle(0);

        // simultaneous requests after reset: req0 first, then the waiting req1
        do_reset();
        gseq.delete();
        drive_pair(0, 20'h00001, 20'h00002, 1, 1);
        wait_idle(0);
        check("pair_grants", gseq.size(), 2);
        for (int i = 0; i < 2; i++) check("pair_grant", gseq[i], exp_g[i]);

        // both held for four transactions: grants alternate
        gseq.delete();
        drive_pair(0, 20'h00001, 20'h00002, 2, 2);
        wait_idle(0);
        check("rr_grants", gseq.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_grant", gseq[i], exp_g[i]);

        // reset during byte 2 of a req1 read, then a clean retry
        drive_pair(0, 20'h00000, 20'h00002, 0, 1);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!fl_ce_n[0] && fl_addr[0][1:0] == 2'd2) break;
        end
        check("reached_byte2", {fl_ce_n[0], fl_addr[0][1:0]}, 3'b010);
        do_reset();
        check("abort_pending", pend[0], 0);
        drive_pair(0, 20'h00000, 20'h00002, 0, 1);
        wait_idle(0);

        // top word address with single-cycle byte timing
        drive_pair(1, 20'h00000, 20'hFFFFF, 0, 1);
        wait_idle(1);

        // address changed right after accept must not affect the read
        drive_pair(0, 20'h00005, 20'h00000, 1, 0);
        r0a[0] = 20'h00007;
        wait_idle(0);

        check("final_pending0", pend[0], 0);
        check("final_pending1", pend[1], 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
